// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: splits core byte/word load-store requests into little-endian byte accesses on an 8-bit RAM port
module mem_access_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_word,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [15:0]       cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3;
  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q, word_q;
  logic [15:0]       wdata_q, rdata_q;
  logic [7:0]        lo_q, hi_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      word_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else
      case (state)
        IDLE: if (cpu_req) begin
          addr_q  <= cpu_addr;
          we_q    <= cpu_we;
          word_q  <= cpu_word;
          wdata_q <= cpu_wdata;
          state   <= LO;
        end
        LO: begin
          if (!we_q) lo_q <= mem_rdata;
          state <= word_q ? HI : DONE;
        end
        HI: begin
          if (!we_q) hi_q <= mem_rdata;
          state <= DONE;
        end
        default: begin
          rdata_q <= cpu_rdata;
          state   <= IDLE;
        end
      endcase
  // load result is presented combinationally in DONE and held in rdata_q afterwards
  always_comb begin
    cpu_busy  = state == LO || state == HI;
    cpu_done  = state == DONE;
    cpu_rdata = cpu_done && !we_q ? (word_q ? {hi_q, lo_q} : {8'h00, lo_q}) : rdata_q;
    mem_addr  = state == HI ? addr_q + ADDR_W'(1) : addr_q;
    mem_read  = cpu_busy && !we_q;
    mem_write = cpu_busy && we_q;
    mem_wdata = mem_write ? (state == HI ? wdata_q[15:8] : wdata_q[7:0]) : 8'h00;
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl against a behavioural 64 KiB byte RAM
module tb_mem_access_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_word = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_busy, cpu_done, mem_read, mem_write;
  logic [15:0] cpu_rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [7:0]  ram [0:65535];
  int          wr_cnt = 0;
  int          n_cmp = 0, n_bad = 0;

  mem_access_ctrl #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_word(cpu_word),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done),
    .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_write) begin
    ram[mem_addr] = mem_wdata;
    wr_cnt = wr_cnt + 1;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic we, input logic word, input logic [15:0] a, input logic [15:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_word = word; cpu_addr = a; cpu_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0101] = 8'h33;
    #12;
    chk("rst_busy", cpu_busy, 0); chk("rst_done", cpu_done, 0); chk("rst_rdata", cpu_rdata, 0);
    chk("rst_read", mem_read, 0); chk("rst_write", mem_write, 0);
    chk("rst_wdata", mem_wdata, 0); chk("rst_addr", mem_addr, 0);
    rst = 1'b0;
    step;
    // word store 0xBEEF @0x1234
    req(1, 1, 16'h1234, 16'hBEEF);
    step; cpu_req = 1'b0;
    chk("ws_lo_busy", cpu_busy, 1); chk("ws_lo_wr", mem_write, 1); chk("ws_lo_rd", mem_read, 0);
    chk("ws_lo_addr", mem_addr, 16'h1234); chk("ws_lo_wdata", mem_wdata, 8'hEF);
    step;
    chk("ws_lo_ram", ram[16'h1234], 8'hEF); chk("ws_hi_addr", mem_addr, 16'h1235);
    chk("ws_hi_wdata", mem_wdata, 8'hBE); chk("ws_hi_wr", mem_write, 1);
    step;
    chk("ws_done", cpu_done, 1); chk("ws_done_busy", cpu_busy, 0); chk("ws_rdata", cpu_rdata, 0);
    chk("ws_hi_ram", ram[16'h1235], 8'hBE); chk("ws_done_wr", mem_write, 0); chk("ws_done_wdata", mem_wdata, 0);
    step;
    chk("ws_idle_done", cpu_done, 0);
    // word load 0x1234
    req(0, 1, 16'h1234, 16'h0);
    step; cpu_req = 1'b0;
    chk("wl_lo_rd", mem_read, 1); chk("wl_lo_wr", mem_write, 0);
    step;
    chk("wl_hi_rd", mem_read, 1); chk("wl_hi_addr", mem_addr, 16'h1235);
    step;
    chk("wl_done", cpu_done, 1); chk("wl_rdata", cpu_rdata, 16'hBEEF); chk("wl_done_rd", mem_read, 0);
    step;
    chk("wl_hold", cpu_rdata, 16'hBEEF);
    // byte load 0x1235
    req(0, 0, 16'h1235, 16'h0);
    step; cpu_req = 1'b0;
    chk("bl_lo_addr", mem_addr, 16'h1235);
    step;
    chk("bl_done", cpu_done, 1); chk("bl_rdata", cpu_rdata, 16'h00BE);
    step;
    // wrap-around word store 0xA55A @0xFFFF
    req(1, 1, 16'hFFFF, 16'hA55A);
    step; cpu_req = 1'b0;
    chk("wr_lo_addr", mem_addr, 16'hFFFF); chk("wr_lo_wdata", mem_wdata, 8'h5A);
    step;
    chk("wr_hi_addr", mem_addr, 16'h0000); chk("wr_hi_wdata", mem_wdata, 8'hA5);
    step;
    chk("wr_ram_ffff", ram[16'hFFFF], 8'h5A); chk("wr_ram_0000", ram[16'h0000], 8'hA5);
    chk("wr_rdata_kept", cpu_rdata, 16'h00BE);
    step;
    req(0, 1, 16'hFFFF, 16'h0);
    step; cpu_req = 1'b0;
    step; step;
    chk("wrl_done", cpu_done, 1); chk("wrl_rdata", cpu_rdata, 16'hA55A);
    step;
    // word loads with req held: 4-cycle repeat, addr changes ignored mid-op
    req(0, 1, 16'h1234, 16'h0);
    for (int k = 0; k < 2; k++) begin
      step; cpu_addr = 16'h4000;
      chk("hl_lo_busy", cpu_busy, 1); chk("hl_lo_addr", mem_addr, 16'h1234);
      step;
      chk("hl_hi_addr", mem_addr, 16'h1235); chk("hl_hi_done", cpu_done, 0);
      step; cpu_addr = 16'h1234;
      chk("hl_done", cpu_done, 1); chk("hl_rdata", cpu_rdata, 16'hBEEF);
      step;
      chk("hl_idle_busy", cpu_busy, 0); chk("hl_idle_done", cpu_done, 0);
    end
    // byte stores with req held: 3-cycle repeat
    req(1, 0, 16'h2000, 16'hFF11);
    for (int k = 0; k < 2; k++) begin
      step;
      chk("hs_lo_wr", mem_write, 1); chk("hs_lo_wdata", mem_wdata, 8'h11);
      step;
      chk("hs_done", cpu_done, 1); chk("hs_rdata", cpu_rdata, 16'hBEEF);
      if (k == 1) cpu_req = 1'b0;
      step;
      chk("hs_idle", cpu_busy, 0);
    end
    chk("hs_ram", ram[16'h2000], 8'h11); chk("hs_ram_next", ram[16'h2001], 8'h00);
    step;
    chk("hs_no_req", cpu_busy, 0);
    // reset during HI of a word store
    req(1, 1, 16'h0100, 16'h1122);
    step; cpu_req = 1'b0;
    step;
    chk("rm_hi_wr", mem_write, 1);
    #2 rst = 1'b1;
    #1;
    chk("rm_wr", mem_write, 0); chk("rm_busy", cpu_busy, 0); chk("rm_addr", mem_addr, 0);
    chk("rm_wdata", mem_wdata, 0); chk("rm_rdata", cpu_rdata, 0);
    step;
    chk("rm_ram_lo", ram[16'h0100], 8'h22); chk("rm_ram_hi", ram[16'h0101], 8'h33);
    chk("rm_done", cpu_done, 0);
    rst = 1'b0;
    step;
    chk("rm_after_done", cpu_done, 0); chk("rm_after_busy", cpu_busy, 0);
    // byte store then byte load at 0x0010
    wr_cnt = 0;
    req(1, 0, 16'h0010, 16'h007F);
    step; cpu_req = 1'b0;
    step;
    chk("bs_done", cpu_done, 1);
    step;
    chk("bs_wr_cnt", wr_cnt, 1); chk("bs_ram", ram[16'h0010], 8'h7F); chk("bs_ram_next", ram[16'h0011], 8'h00);
    req(0, 0, 16'h0010, 16'h0);
    step; cpu_req = 1'b0;
    step;
    chk("bsl_done", cpu_done, 1); chk("bsl_rdata", cpu_rdata, 16'h007F);
    step;
    chk("bsl_hold", cpu_rdata, 16'h007F);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
